// File: rtl/mux_4x1.sv
// mux_4x1: 4-to-1 multiplexer with a one-hot select decode
// and an enable-gated registered copy of the result and select.
module mux_4x1 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       S,
   input  logic [WIDTH-1:0] D0,
   input  logic [WIDTH-1:0] D1,
   input  logic [WIDTH-1:0] D2,
   input  logic [WIDTH-1:0] D3,
   input  logic             en,
   output logic [WIDTH-1:0] Y,
   output logic [WIDTH-1:0] Y_q,
   output logic [1:0]       S_q,
   output logic [3:0]       sel_onehot
);

   logic [WIDTH-1:0] cap_y_q;
   logic [WIDTH-1:0] cap_y_d;
   logic [1:0]       cap_s_q;
   logic [1:0]       cap_s_d;

   // An unknown select falls through to default and forces zeros.
   always_comb begin
      Y          = '0;
      sel_onehot = 4'b0000;
      case (S)
         2'b00: begin
            Y          = D0;
            sel_onehot = 4'b0001;
         end
         2'b01: begin
            Y          = D1;
            sel_onehot = 4'b0010;
         end
         2'b10: begin
            Y          = D2;
            sel_onehot = 4'b0100;
         end
         2'b11: begin
            Y          = D3;
            sel_onehot = 4'b1000;
         end
         default: begin
            Y          = '0;
            sel_onehot = 4'b0000;
         end
      endcase
   end

   always_comb begin
      cap_y_d = cap_y_q;
      cap_s_d = cap_s_q;
      if (en) begin
         cap_y_d = Y;
         cap_s_d = S;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_y_q <= '0;
         cap_s_q <= 2'b00;
      end else begin
         cap_y_q <= cap_y_d;
         cap_s_q <= cap_s_d;
      end
   end

   assign Y_q = cap_y_q;
   assign S_q = cap_s_q;

endmodule

// File: tb/tb_mux_4x1.sv
// tb_mux_4x1: randomized and directed checks of mux_4x1
// against a behavioural select/capture model.
`timescale 1ns/100ps
module tb_mux_4x1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] S = 2'b00;
   logic [3:0] dv = 4'b0000;
   logic       en = 1'b0;
   logic       Y;
   logic       Y_q;
   logic [1:0] S_q;
   logic [3:0] sel_onehot;

   int errors = 0;
   int checks = 0;

   logic       m_yq = 1'b0;
   logic [1:0] m_sq = 2'b00;

   mux_4x1 #(.WIDTH(1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .S          (S),
      .D0         (dv[0]),
      .D1         (dv[1]),
      .D2         (dv[2]),
      .D3         (dv[3]),
      .en         (en),
      .Y          (Y),
      .Y_q        (Y_q),
      .S_q        (S_q),
      .sel_onehot (sel_onehot)
   );

   always #5 clk = ~clk;

   function automatic logic ref_y(input logic [1:0] s, input logic [3:0] d);
      return d[s];
   endfunction

   function automatic logic [3:0] ref_oh(input logic [1:0] s);
      return 4'(1) << s;
   endfunction

   // drive at negedge, model the capture, check after the posedge
   task automatic clk_step(input logic [1:0] s, input logic [3:0] d, input logic e);
      @(negedge clk);
      S = s; dv = d; en = e;
      if (e && rst_n) begin
         m_yq = ref_y(s, d);
         m_sq = s;
      end
      @(posedge clk);
      #1;
      checks++;
      if (Y_q !== m_yq || S_q !== m_sq) begin
         errors++;
         $display("FAIL clk_step: Y_q=%b S_q=%b expected Y_q=%b S_q=%b",
                  Y_q, S_q, m_yq, m_sq);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; S = 2'b10; dv = 4'b0100; en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (Y_q !== 1'b0 || S_q !== 2'b00) begin
         errors++;
         $display("FAIL reset_regs: Y_q=%b S_q=%b expected 0 00", Y_q, S_q);
      end
      checks++;
      if (Y !== 1'b1 || sel_onehot !== 4'b0100) begin
         errors++;
         $display("FAIL reset_comb: Y=%b oh=%b expected 1 0100", Y, sel_onehot);
      end
      @(negedge clk);
      rst_n = 1'b1;
      m_yq = 1'b0; m_sq = 2'b00;
      clk_step(2'b11, 4'b1000, 1'b1);
   endtask

   task automatic test_toggle_sweep();
      for (int t = 0; t < 64; t++) begin
         logic [5:0] tt;
         tt = 6'(t);
         dv = tt[3:0];
         S  = tt[5:4];
         #0.5;
         checks++;
         if (Y !== ref_y(S, dv)) begin
            errors++;
            $display("FAIL toggle_sweep t=%0d: Y=%b expected %b", t, Y, ref_y(S, dv));
         end
         #0.5;
      end
   endtask

   task automatic test_static_select();
      logic [3:0] ey;
      ey = 4'b0101;
      dv = 4'b0101;
      for (int s = 0; s < 4; s++) begin
         S = 2'(s);
         #1;
         checks++;
         if (Y !== ey[s] || sel_onehot !== ref_oh(2'(s))) begin
            errors++;
            $display("FAIL static_select s=%0d: Y=%b oh=%b expected %b %b",
                     s, Y, sel_onehot, ey[s], ref_oh(2'(s)));
         end
      end
   endtask

   task automatic test_registered();
      clk_step(2'b10, 4'b0100, 1'b1);
      checks++;
      if (Y_q !== 1'b1 || S_q !== 2'b10) begin
         errors++;
         $display("FAIL registered_load: Y_q=%b S_q=%b expected 1 10", Y_q, S_q);
      end
      clk_step(2'b10, 4'b0000, 1'b0);
      clk_step(2'b01, 4'b0000, 1'b0);
      checks++;
      if (Y_q !== 1'b1 || S_q !== 2'b10) begin
         errors++;
         $display("FAIL registered_hold: Y_q=%b S_q=%b expected 1 10", Y_q, S_q);
      end
   endtask

   task automatic test_async_reset();
      clk_step(2'b11, 4'b1000, 1'b1);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      m_yq = 1'b0; m_sq = 2'b00;
      #1;
      checks++;
      if (Y_q !== 1'b0 || S_q !== 2'b00 || Y !== 1'b1) begin
         errors++;
         $display("FAIL async_reset: Y_q=%b S_q=%b Y=%b expected 0 00 1",
                  Y_q, S_q, Y);
      end
      @(posedge clk);
      #1;
      checks++;
      if (Y_q !== 1'b0 || S_q !== 2'b00) begin
         errors++;
         $display("FAIL reset_hold: Y_q=%b S_q=%b expected 0 00", Y_q, S_q);
      end
      @(negedge clk);
      rst_n = 1'b1;
      clk_step(2'b01, 4'b0010, 1'b1);
   endtask

   task automatic test_isolation();
      S = 2'b01;
      for (int i = 0; i < 32; i++) begin
         dv = 4'($urandom) & 4'b1101;
         #1;
         checks++;
         if (Y !== 1'b0) begin
            errors++;
            $display("FAIL isolation i=%0d: Y=%b expected 0 (dv=%b)", i, Y, dv);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 200; i++) begin
         logic [1:0] s;
         logic [3:0] d;
         s = 2'($urandom);
         d = 4'($urandom);
         clk_step(s, d, 1'($urandom_range(0, 3) != 0));
         checks++;
         if (Y !== ref_y(s, d) || sel_onehot !== ref_oh(s)) begin
            errors++;
            $display("FAIL random_comb i=%0d: Y=%b oh=%b expected %b %b",
                     i, Y, sel_onehot, ref_y(s, d), ref_oh(s));
         end
      end
   endtask

   initial begin
      test_reset();
      test_toggle_sweep();
      test_static_select();
      test_registered();
      test_async_reset();
      test_isolation();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
